// File: rtl/ifmd_stream_loader.sv
// ---------------------------------------------------------------------------
// ifmd_stream_loader
//   Streams one channel of a preloaded input-feature-map image into the IFMD
//   buffer write port, one word per accepted cycle. A start request latches the
//   channel and the word count. The downstream port can stall the stream. An
//   abort ends the load without the completion pulse. busy and write_done give
//   the host a simple handshake.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   write_en     start request, only honoured while idle
//   ch_sel       channel to load (clamped to NUM_CH-1)
//   word_count   words to load; 0 or more than DEPTH loads the whole channel
//   write_ready  downstream accepts a word on this edge; 0 stalls the stream
//   abort        stop the current load, no write_done
//   busy         high from accepted start until back in idle
//   write_done   one-cycle pulse after the last word
//   IFMD_write   buffer write strobe
//   write_addr   buffer address, 0..len-1
//   IFMD_in      buffer write data
// ---------------------------------------------------------------------------
module ifmd_stream_loader #(
  parameter int    DATA_W    = 8,
  parameter int    DEPTH     = 64,
  parameter int    NUM_CH    = 4,
  parameter int    ADDR_W    = $clog2(DEPTH),
  parameter int    CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter string INIT_FILE = "TM/IFMD_DATA.mem"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [ADDR_W:0]   word_count,
  input  logic              write_ready,
  input  logic              abort,
  output logic              busy,
  output logic              write_done,
  output logic              IFMD_write,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] IFMD_in
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int              IDX_W   = ADDR_W + CH_W;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [CH_W-1:0] CH_MAX  = CH_W'(NUM_CH - 1);

  // Image store: channel c occupies image_mem[c*DEPTH +: DEPTH].
  // NOTE: the image is a preloaded ROM. Reset never clears it, so a reset in
  // the middle of a load leaves the image intact for the next load.
  logic [DATA_W-1:0] image_mem [NUM_CH*DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;   // one extra bit so len=DEPTH ends without wrap
  logic [ADDR_W:0]   len_q, len_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              busy_q, busy_d;
  logic              write_done_q, write_done_d;
  logic              ifmd_write_q, ifmd_write_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [DATA_W-1:0] ifmd_in_q, ifmd_in_d;

  logic [CH_W-1:0]   ch_clamped;
  logic [IDX_W-1:0]  rd_idx;

  // Only build the clamp when ch_sel can encode a channel that does not exist.
  generate
    if ((2 ** CH_W) > NUM_CH) begin : g_ch_clamp
      assign ch_clamped = (ch_sel > CH_MAX) ? CH_MAX : ch_sel;
    end else begin : g_ch_pass
      assign ch_clamped = ch_sel;
    end
  endgenerate

  // DEPTH is a power of two, so ch*DEPTH+count is a plain concatenation.
  // A carry can never spill into the next channel.
  assign rd_idx = {ch_q, count_q[ADDR_W-1:0]};

  always_comb begin
    // NOTE: every _d gets a default first. The FSM branches then only list
    // what changes, and no path can leave a signal unassigned and infer a latch.
    state_d      = state_q;
    count_d      = count_q;
    len_d        = len_q;
    ch_d         = ch_q;
    busy_d       = busy_q;
    write_done_d = 1'b0;
    ifmd_write_d = 1'b0;
    write_addr_d = write_addr_q;
    ifmd_in_d    = ifmd_in_q;

    case (state_q)
      ST_IDLE: begin
        if (write_en) begin
          ch_d    = ch_clamped;
          len_d   = ((word_count == '0) || (word_count > DEPTH_W)) ? DEPTH_W : word_count;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        // Priority: abort, then completion, then transfer or stall.
        if (abort) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (count_q == len_q) begin
          write_done_d = 1'b1;
          state_d      = ST_DONE;
        end else if (write_ready) begin
          ifmd_write_d = 1'b1;
          write_addr_d = count_q[ADDR_W-1:0];
          ifmd_in_d    = image_mem[rd_idx];
          count_d      = count_q + (ADDR_W + 1)'(1);
        end
        // Stall: the strobe drops, and address, data and count keep their values.
      end

      ST_DONE: begin
        // A start request seen here is dropped. It is not carried over.
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples the pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      len_q        <= '0;
      ch_q         <= '0;
      busy_q       <= 1'b0;
      write_done_q <= 1'b0;
      ifmd_write_q <= 1'b0;
      write_addr_q <= '0;
      ifmd_in_q    <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      len_q        <= len_d;
      ch_q         <= ch_d;
      busy_q       <= busy_d;
      write_done_q <= write_done_d;
      ifmd_write_q <= ifmd_write_d;
      write_addr_q <= write_addr_d;
      ifmd_in_q    <= ifmd_in_d;
    end
  end

  assign busy       = busy_q;
  assign write_done = write_done_q;
  assign IFMD_write = ifmd_write_q;
  assign write_addr = write_addr_q;
  assign IFMD_in    = ifmd_in_q;

endmodule

// File: tb/tb_ifmd_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_ifmd_stream_loader
//   Directed bench for ifmd_stream_loader. The image store is filled with a
//   known pattern. A monitor samples the outputs 2 ns after each rising edge
//   and logs every strobe. Each scenario task drives inputs on the falling
//   edge and checks against hand-derived values.
// ---------------------------------------------------------------------------
module tb_ifmd_stream_loader;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 6;
  localparam int CH_W   = 2;

  logic              clk         = 1'b0;
  logic              rst         = 1'b1;
  logic              write_en    = 1'b0;
  logic [CH_W-1:0]   ch_sel      = '0;
  logic [ADDR_W:0]   word_count  = '0;
  logic              write_ready = 1'b1;
  logic              abort       = 1'b0;
  logic              busy;
  logic              write_done;
  logic              IFMD_write;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] IFMD_in;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Monitor state
  int cyc = 0;
  int done_cnt, busy_cycles, first_cyc, done_cyc;
  logic [ADDR_W-1:0] s_addr [$];
  logic [DATA_W-1:0] s_data [$];

  ifmd_stream_loader #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH),
    .ADDR_W(ADDR_W), .CH_W(CH_W), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .ch_sel(ch_sel),
    .word_count(word_count), .write_ready(write_ready), .abort(abort),
    .busy(busy), .write_done(write_done), .IFMD_write(IFMD_write),
    .write_addr(write_addr), .IFMD_in(IFMD_in)
  );

  always #5 clk = ~clk;

  // Image pattern. 37 is odd, so every store index gets a distinct byte.
  function automatic logic [DATA_W-1:0] img(input int i);
    return DATA_W'(i * 37 + 11);
  endfunction

  always @(posedge clk) begin
    cyc++;
    #2;
    if (IFMD_write) begin
      s_addr.push_back(write_addr);
      s_data.push_back(IFMD_in);
      if (first_cyc < 0) first_cyc = cyc;
    end
    if (write_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cycles++;
  end

  task automatic clear_mon();
    s_addr.delete();
    s_data.delete();
    done_cnt    = 0;
    busy_cycles = 0;
    first_cyc   = -1;
    done_cyc    = -1;
  endtask

  // Called on a falling edge with the DUT idle. It returns on the next falling
  // edge with n = index of the rising edge that accepted the start.
  task automatic start_load(input logic [CH_W-1:0] ch, input logic [ADDR_W:0] wc, output int n);
    ch_sel     = ch;
    word_count = wc;
    write_en   = 1'b1;
    @(negedge clk);
    write_en   = 1'b0;
    n          = cyc;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total_cnt++; if (busy !== 1'b0)       $display("FAIL reset_busy: got %b want 0", busy);             else pass_cnt++;
    total_cnt++; if (write_done !== 1'b0) $display("FAIL reset_done: got %b want 0", write_done);       else pass_cnt++;
    total_cnt++; if (IFMD_write !== 1'b0) $display("FAIL reset_strobe: got %b want 0", IFMD_write);     else pass_cnt++;
    total_cnt++; if (write_addr !== '0)   $display("FAIL reset_addr: got %0d want 0", write_addr);      else pass_cnt++;
    total_cnt++; if (IFMD_in !== '0)      $display("FAIL reset_data: got %0h want 0", IFMD_in);         else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ch 0, word_count 0 -> full 64-word channel with exact latency.
  task automatic test_full_channel();
    int n; bit to;
    clear_mon();
    start_load(2'd0, 7'd0, n);
    wait_idle(200, to);
    total_cnt++; if (to) $display("FAIL t1_timeout: busy still high after 200 cycles"); else pass_cnt++;
    total_cnt++; if (s_addr.size() != 64) $display("FAIL t1_count: got %0d strobes want 64", s_addr.size()); else pass_cnt++;
    for (int i = 0; i < s_addr.size() && i < 64; i++) begin
      total_cnt++;
      if (s_addr[i] !== ADDR_W'(i) || s_data[i] !== img(i))
        $display("FAIL t1_word[%0d]: got addr %0d data %0h want addr %0d data %0h", i, s_addr[i], s_data[i], i, img(i));
      else pass_cnt++;
    end
    total_cnt++; if (first_cyc != n + 1)  $display("FAIL t1_first: got edge %0d want %0d", first_cyc, n + 1); else pass_cnt++;
    total_cnt++; if (done_cnt != 1)       $display("FAIL t1_done_cnt: got %0d want 1", done_cnt);            else pass_cnt++;
    total_cnt++; if (done_cyc != n + 65)  $display("FAIL t1_done_edge: got %0d want %0d", done_cyc, n + 65); else pass_cnt++;
    total_cnt++; if (busy_cycles != 66)   $display("FAIL t1_busy_len: got %0d want 66", busy_cycles);        else pass_cnt++;
  endtask

  // ch 2, 5 words -> store[128..132].
  task automatic test_short_load();
    int n; bit to;
    clear_mon();
    start_load(2'd2, 7'd5, n);
    wait_idle(50, to);
    @(negedge clk);
    total_cnt++; if (to) $display("FAIL t2_timeout: busy still high after 50 cycles"); else pass_cnt++;
    total_cnt++; if (s_addr.size() != 5) $display("FAIL t2_count: got %0d strobes want 5", s_addr.size()); else pass_cnt++;
    for (int i = 0; i < s_addr.size() && i < 5; i++) begin
      total_cnt++;
      if (s_addr[i] !== ADDR_W'(i) || s_data[i] !== img(128 + i))
        $display("FAIL t2_word[%0d]: got addr %0d data %0h want addr %0d data %0h", i, s_addr[i], s_data[i], i, img(128 + i));
      else pass_cnt++;
    end
    total_cnt++; if (done_cnt != 1)  $display("FAIL t2_done_cnt: got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0)  $display("FAIL t2_busy_after: got %b want 0", busy);    else pass_cnt++;
  endtask

  // ch 1, 8 words, 3-cycle stall after the 3rd word.
  task automatic test_stall();
    int n; bit to;
    clear_mon();
    start_load(2'd1, 7'd8, n);
    repeat (3) @(negedge clk);
    write_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total_cnt++; if (IFMD_write !== 1'b0)   $display("FAIL t3_stall_strobe[%0d]: got %b want 0", k, IFMD_write); else pass_cnt++;
      total_cnt++; if (write_addr !== 6'd2)   $display("FAIL t3_stall_addr[%0d]: got %0d want 2", k, write_addr);  else pass_cnt++;
      total_cnt++; if (IFMD_in !== img(66))   $display("FAIL t3_stall_data[%0d]: got %0h want %0h", k, IFMD_in, img(66)); else pass_cnt++;
    end
    write_ready = 1'b1;
    wait_idle(50, to);
    total_cnt++; if (to) $display("FAIL t3_timeout: busy still high after 50 cycles"); else pass_cnt++;
    total_cnt++; if (s_addr.size() != 8) $display("FAIL t3_count: got %0d strobes want 8", s_addr.size()); else pass_cnt++;
    for (int i = 0; i < s_addr.size() && i < 8; i++) begin
      total_cnt++;
      if (s_addr[i] !== ADDR_W'(i) || s_data[i] !== img(64 + i))
        $display("FAIL t3_word[%0d]: got addr %0d data %0h want addr %0d data %0h", i, s_addr[i], s_data[i], i, img(64 + i));
      else pass_cnt++;
    end
    total_cnt++; if (done_cnt != 1) $display("FAIL t3_done_cnt: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  // ch 3, 100 words (clamped), abort after the 10th word, then a clean restart.
  task automatic test_abort();
    int n; bit to;
    clear_mon();
    start_load(2'd3, 7'd100, n);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total_cnt++; if (IFMD_write !== 1'b0) $display("FAIL t4_abort_strobe: got %b want 0", IFMD_write); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0)       $display("FAIL t4_abort_busy: got %b want 0", busy);         else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (s_addr.size() != 10) $display("FAIL t4_count: got %0d strobes want 10", s_addr.size()); else pass_cnt++;
    for (int i = 0; i < s_addr.size() && i < 10; i++) begin
      total_cnt++;
      if (s_addr[i] !== ADDR_W'(i) || s_data[i] !== img(192 + i))
        $display("FAIL t4_word[%0d]: got addr %0d data %0h want addr %0d data %0h", i, s_addr[i], s_data[i], i, img(192 + i));
      else pass_cnt++;
    end
    total_cnt++; if (done_cnt != 0) $display("FAIL t4_done_cnt: got %0d want 0", done_cnt); else pass_cnt++;

    clear_mon();
    start_load(2'd0, 7'd3, n);
    wait_idle(50, to);
    total_cnt++; if (to) $display("FAIL t4_restart_timeout: busy still high after 50 cycles"); else pass_cnt++;
    total_cnt++; if (s_addr.size() != 3) $display("FAIL t4_restart_count: got %0d strobes want 3", s_addr.size()); else pass_cnt++;
    for (int i = 0; i < s_addr.size() && i < 3; i++) begin
      total_cnt++;
      if (s_addr[i] !== ADDR_W'(i) || s_data[i] !== img(i))
        $display("FAIL t4_restart_word[%0d]: got addr %0d data %0h want addr %0d data %0h", i, s_addr[i], s_data[i], i, img(i));
      else pass_cnt++;
    end
    total_cnt++; if (done_cnt != 1) $display("FAIL t4_restart_done: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  // Abort on the same edge as the final word: abort wins, no last word, no done.
  task automatic test_abort_last();
    int n;
    clear_mon();
    start_load(2'd2, 7'd3, n);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (s_addr.size() != 2) $display("FAIL t_abl_count: got %0d strobes want 2", s_addr.size()); else pass_cnt++;
    total_cnt++; if (done_cnt != 0)      $display("FAIL t_abl_done: got %0d want 0", done_cnt);              else pass_cnt++;
    total_cnt++; if (busy !== 1'b0)      $display("FAIL t_abl_busy: got %b want 0", busy);                  else pass_cnt++;
  endtask

  // word_count above DEPTH loads the whole channel. An abort held on the start edge is ignored.
  task automatic test_clamp();
    int n; bit to;
    clear_mon();
    abort = 1'b1;
    start_load(2'd1, 7'd65, n);
    abort = 1'b0;
    wait_idle(200, to);
    total_cnt++; if (to) $display("FAIL tc_timeout: busy still high after 200 cycles"); else pass_cnt++;
    total_cnt++; if (s_addr.size() != 64) $display("FAIL tc_count: got %0d strobes want 64", s_addr.size()); else pass_cnt++;
    total_cnt++;
    if (s_addr.size() == 64 && (s_addr[63] !== 6'd63 || s_data[63] !== img(127)))
      $display("FAIL tc_last_word: got addr %0d data %0h want addr 63 data %0h", s_addr[63], s_data[63], img(127));
    else pass_cnt++;
    total_cnt++; if (done_cnt != 1) $display("FAIL tc_done_cnt: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  // Asynchronous reset between edges in the middle of a load.
  task automatic test_async_reset();
    int n; bit to;
    clear_mon();
    start_load(2'd1, 7'd64, n);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0)       $display("FAIL t5_busy: got %b want 0", busy);         else pass_cnt++;
    total_cnt++; if (IFMD_write !== 1'b0) $display("FAIL t5_strobe: got %b want 0", IFMD_write); else pass_cnt++;
    total_cnt++; if (write_addr !== '0)   $display("FAIL t5_addr: got %0d want 0", write_addr);  else pass_cnt++;
    total_cnt++; if (IFMD_in !== '0)      $display("FAIL t5_data: got %0h want 0", IFMD_in);     else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_mon();
    start_load(2'd1, 7'd4, n);
    wait_idle(50, to);
    total_cnt++; if (to) $display("FAIL t5_timeout: busy still high after 50 cycles"); else pass_cnt++;
    total_cnt++; if (s_addr.size() != 4) $display("FAIL t5_count: got %0d strobes want 4", s_addr.size()); else pass_cnt++;
    for (int i = 0; i < s_addr.size() && i < 4; i++) begin
      total_cnt++;
      if (s_addr[i] !== ADDR_W'(i) || s_data[i] !== img(64 + i))
        $display("FAIL t5_word[%0d]: got addr %0d data %0h want addr %0d data %0h", i, s_addr[i], s_data[i], i, img(64 + i));
      else pass_cnt++;
    end
    total_cnt++; if (done_cnt != 1) $display("FAIL t5_done_cnt: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  // write_en held for 15 edges with 2-word loads: starts at S, S+5, S+10.
  // ch/len are changed while busy and must be ignored.
  task automatic test_back_to_back();
    bit to;
    clear_mon();
    ch_sel     = 2'd0;
    word_count = 7'd2;
    write_en   = 1'b1;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (j == 1) begin ch_sel = 2'd3; word_count = 7'd7; end
      if (j == 3) begin ch_sel = 2'd0; word_count = 7'd2; end
    end
    write_en = 1'b0;
    wait_idle(20, to);
    repeat (2) @(negedge clk);
    total_cnt++; if (to) $display("FAIL t6_timeout: busy still high after 20 cycles"); else pass_cnt++;
    total_cnt++; if (s_addr.size() != 6) $display("FAIL t6_count: got %0d strobes want 6", s_addr.size()); else pass_cnt++;
    for (int i = 0; i < s_addr.size() && i < 6; i++) begin
      total_cnt++;
      if (s_addr[i] !== ADDR_W'(i % 2) || s_data[i] !== img(i % 2))
        $display("FAIL t6_word[%0d]: got addr %0d data %0h want addr %0d data %0h", i, s_addr[i], s_data[i], i % 2, img(i % 2));
      else pass_cnt++;
    end
    total_cnt++; if (done_cnt != 3)     $display("FAIL t6_done_cnt: got %0d want 3", done_cnt);     else pass_cnt++;
    total_cnt++; if (busy_cycles != 12) $display("FAIL t6_busy_len: got %0d want 12", busy_cycles); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < NUM_CH * DEPTH; i++) dut.image_mem[i] = img(i);
    clear_mon();
    test_reset();
    test_full_channel();
    test_short_load();
    test_stall();
    test_abort();
    test_abort_last();
    test_clamp();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
